// File: rtl/fc_pkg.sv
// Shared FC-layer definitions: default word/address widths and the memory responder FSM states.
package fc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    RD_FETCH,
    RD_SEND,
    WR_DATA
  } fc_state_t;

endpackage

// File: rtl/fc_sram.sv
// Single-port synchronous-read SRAM, one-cycle read latency; only the read register is reset.
module fc_sram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage survives reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only updates on reads, so it holds while a beat is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/fc_mem_responder.sv
// Burst memory responder for the FC engine: validates requests, streams read beats
// (one per two cycles) from a synchronous SRAM and accepts write beats.
module fc_mem_responder #(
  parameter int unsigned DATA_W  = fc_pkg::DATA_W,
  parameter int unsigned ADDR_W  = fc_pkg::ADDR_W,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              busy,
  output logic              err
);

  import fc_pkg::*;

  fc_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;

  logic [31:0]       end_c;
  logic              bad_c;
  logic              last_c;
  logic              wr_fire_c;
  logic              sram_en_c;
  logic              sram_we_c;

  // Request rejected when empty, too long, or running past the end of memory
  assign end_c  = 32'(req_addr) + 32'(req_len);
  assign bad_c  = (req_len == '0) || (32'(req_len) > MAX_LEN) || (end_c > DEPTH);
  assign last_c = (cnt_q == len_q - LEN_W'(1));

  assign wr_fire_c = (state_q == WR_DATA) && wr_valid && wr_ready;
  assign sram_en_c = (state_q == RD_FETCH) || wr_fire_c;
  assign sram_we_c = (state_q == WR_DATA);

  fc_sram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .en    (sram_en_c),
    .we    (sram_we_c),
    .addr  (addr_q),
    .wdata (wr_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      err <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (bad_c) begin
              err <= 1'b1;
            end else begin
              addr_q    <= req_addr;
              len_q     <= req_len;
              cnt_q     <= '0;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              if (req_write) begin
                state_q  <= WR_DATA;
                wr_ready <= 1'b1;
              end else begin
                state_q <= RD_FETCH;
              end
            end
          end
        end
        RD_FETCH: begin
          state_q  <= RD_SEND;
          rd_valid <= 1'b1;
          rd_last  <= last_c;
        end
        RD_SEND: begin
          if (rd_valid && rd_ready) begin
            addr_q   <= addr_q + ADDR_W'(1);
            cnt_q    <= cnt_q + LEN_W'(1);
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (last_c) begin
              state_q   <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state_q <= RD_FETCH;
            end
          end
        end
        WR_DATA: begin
          if (wr_fire_c) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q + LEN_W'(1);
            if (last_c) begin
              state_q   <= IDLE;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
